// File: rtl/mem_pkg.sv
// Shared widths and the store-buffer entry type for the data memory responder.
package mem_pkg;

  localparam int MEM_DATA_W = 16;
  localparam int MEM_ADDR_W = 10;

  typedef struct packed {
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/data_mem_responder_store_buffer.sv
// Circular store buffer holding posted stores, with a youngest-match lookup
// used to forward buffered data to loads.
module store_buffer
  import mem_pkg::*;
#(
  parameter int SB_DEPTH = 4,
  localparam int PTR_W = $clog2(SB_DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  sb_entry_t             push_entry,
  input  logic                  pop,
  output sb_entry_t             head_entry,
  output logic [CNT_W-1:0]      count,
  input  logic [MEM_ADDR_W-1:0] lookup_addr,
  output logic                  hit,
  output logic [MEM_DATA_W-1:0] hit_data
);

  sb_entry_t        entries [SB_DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Entry storage needs no reset: count alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (push) entries[tail] <= push_entry;
  end

  assign head_entry = entries[head];

  // Scanning oldest to youngest and letting later matches overwrite earlier ones
  // gives the same answer as a priority scan from tail-1 back to head.
  always_comb begin
    logic [PTR_W-1:0] idx;
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if ((CNT_W'(i) < count) && (entries[idx].addr == lookup_addr)) begin
        hit      = 1'b1;
        hit_data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder: read-only fetch port plus a load/store port whose stores
// are posted into a store buffer and drained into RAM when the data port is idle.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int    DATA_W    = MEM_DATA_W,
  parameter int    ADDR_W    = MEM_ADDR_W,
  parameter int    SB_DEPTH  = 4,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       instr_addr,
  output logic [DATA_W-1:0] instr_data,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [15:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              stall,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              sb_empty
);

  localparam int CNT_W = $clog2(SB_DEPTH) + 1;

  logic [DATA_W-1:0] ram [2**ADDR_W];

  logic [ADDR_W-1:0] data_idx;
  logic [ADDR_W-1:0] fetch_idx;
  logic              push;
  logic              drain;
  logic              load;
  logic [CNT_W-1:0]  count;
  logic              hit;
  logic [DATA_W-1:0] hit_data;
  sb_entry_t         head_entry;
  sb_entry_t         push_entry;
  logic              unused_upper_bits;

  // Upper address bits alias onto the same RAM word.
  assign data_idx          = req_addr[ADDR_W-1:0];
  assign fetch_idx         = instr_addr[ADDR_W-1:0];
  assign unused_upper_bits = ^{instr_addr[15:ADDR_W], req_addr[15:ADDR_W]};

  assign stall      = req_valid & req_write & (count == CNT_W'(SB_DEPTH));
  assign push       = req_valid & req_write & ~stall;
  assign load       = req_valid & ~req_write;
  assign drain      = (count != '0) & (~req_valid | stall);
  assign sb_empty   = (count == '0);
  assign push_entry = '{addr: data_idx, data: req_wdata};

  store_buffer #(.SB_DEPTH(SB_DEPTH)) u_store_buffer (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (push),
    .push_entry  (push_entry),
    .pop         (drain),
    .head_entry  (head_entry),
    .count       (count),
    .lookup_addr (data_idx),
    .hit         (hit),
    .hit_data    (hit_data)
  );

  always_ff @(posedge clk) begin
    if (drain) ram[head_entry.addr] <= head_entry.data;
  end

  // Fetch bypasses the store buffer; loads take the youngest buffered store first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_data <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
    end else begin
      instr_data <= ram[fetch_idx];
      resp_valid <= load;
      if (load) resp_rdata <= hit ? hit_data : ram[data_idx];
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder: forwarding, youngest-store
// priority, full-buffer stall, address aliasing and reset discarding pending stores.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] instr_addr = '0;
  logic [15:0] instr_data;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [15:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        stall;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic        sb_empty;

  int   passes = 0;
  int   checks = 0;
  int   fails  = 0;
  logic stall_seen;

  data_mem_responder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr_addr (instr_addr),
    .instr_data (instr_data),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .stall      (stall),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .sb_empty   (sb_empty)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One request cycle: stall is sampled mid-cycle, outputs are valid #1 after the edge.
  task automatic apply_stimulus(input logic v, input logic w, input logic [15:0] a, input logic [15:0] d);
    req_valid = v;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    @(negedge clk);
    stall_seen = stall;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic check_load(input string tag, input logic [15:0] addr, input logic [15:0] expected);
    apply_stimulus(1'b1, 1'b0, addr, 16'h0000);
    check_output({tag, "_valid"}, 32'(resp_valid), 32'd1);
    check_output({tag, "_data"}, 32'(resp_rdata), 32'(expected));
  endtask

  initial begin
    #2;
    check_output("reset_resp_valid", 32'(resp_valid), 32'd0);
    check_output("reset_resp_rdata", 32'(resp_rdata), 32'd0);
    check_output("reset_instr_data", 32'(instr_data), 32'd0);
    check_output("reset_sb_empty", 32'(sb_empty), 32'd1);
    check_output("reset_stall", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Known RAM contents for the reset-discard scenario later on.
    apply_stimulus(1'b1, 1'b1, 16'h0020, 16'hA001);
    apply_stimulus(1'b1, 1'b1, 16'h0021, 16'hA002);
    apply_stimulus(1'b1, 1'b1, 16'h0022, 16'hA003);
    idle(4);
    check_output("preload_sb_empty", 32'(sb_empty), 32'd1);

    // Forwarding from the buffer.
    apply_stimulus(1'b1, 1'b1, 16'h0005, 16'h1234);
    check_output("fwd_store_no_resp", 32'(resp_valid), 32'd0);
    check_load("fwd_load", 16'h0005, 16'h1234);
    check_output("fwd_sb_empty", 32'(sb_empty), 32'd0);
    idle(1);
    check_output("fwd_idle_no_resp", 32'(resp_valid), 32'd0);
    idle(2);

    // Youngest store to an address wins, and the drained RAM copy agrees.
    apply_stimulus(1'b1, 1'b1, 16'h000A, 16'h1111);
    apply_stimulus(1'b1, 1'b1, 16'h000A, 16'h2222);
    check_load("young_fwd", 16'h000A, 16'h2222);
    idle(3);
    check_output("young_sb_empty", 32'(sb_empty), 32'd1);
    check_load("young_ram", 16'h000A, 16'h2222);

    // Full buffer: fifth store stalls once while the head drains.
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b1, 1'b1, 16'(16'h0040 + i), 16'(16'h4000 + i));
      check_output("full_nostall", 32'(stall_seen), 32'd0);
    end
    apply_stimulus(1'b1, 1'b1, 16'h0044, 16'h4004);
    check_output("full_stall", 32'(stall_seen), 32'd1);
    apply_stimulus(1'b1, 1'b1, 16'h0044, 16'h4004);
    check_output("full_accept", 32'(stall_seen), 32'd0);
    for (int i = 0; i < 5; i++) check_load("full_readback", 16'(16'h0040 + i), 16'(16'h4000 + i));
    idle(5);
    check_output("full_drained", 32'(sb_empty), 32'd1);
    check_load("full_ram", 16'h0044, 16'h4004);

    // Upper address bits alias; fetch ignores the buffer until the drain lands.
    apply_stimulus(1'b1, 1'b1, 16'h0405, 16'hBEEF);
    instr_addr = 16'h0005;
    check_load("wrap_load", 16'h0005, 16'hBEEF);
    check_output("wrap_fetch_old", 32'(instr_data), 32'h1234);
    idle(2);
    check_output("wrap_fetch_new", 32'(instr_data), 32'hBEEF);

    // Reset with stores pending discards them.
    apply_stimulus(1'b1, 1'b1, 16'h0020, 16'hC001);
    apply_stimulus(1'b1, 1'b1, 16'h0021, 16'hC002);
    apply_stimulus(1'b1, 1'b1, 16'h0022, 16'hC003);
    check_output("pend_sb_empty", 32'(sb_empty), 32'd0);
    check_load("pend_fwd", 16'h0021, 16'hC002);
    req_valid = 1'b1;
    req_write = 1'b1;
    rst_n = 1'b0;
    #1;
    check_output("midreset_resp_valid", 32'(resp_valid), 32'd0);
    check_output("midreset_resp_rdata", 32'(resp_rdata), 32'd0);
    check_output("midreset_instr_data", 32'(instr_data), 32'd0);
    check_output("midreset_sb_empty", 32'(sb_empty), 32'd1);
    check_output("midreset_stall", 32'(stall), 32'd0);
    req_valid = 1'b0;
    req_write = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_load("post_reset_20", 16'h0020, 16'hA001);
    check_load("post_reset_21", 16'h0021, 16'hA002);
    check_load("post_reset_22", 16'h0022, 16'hA003);
    check_output("post_reset_sb_empty", 32'(sb_empty), 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
